// File: rtl/fpro_avalon_master_core.sv
// FPro MMIO slot that issues single Avalon-MM read/write transactions on behalf of software.
// Handles waitrequest stalls and pipelined readdatavalid, with a cycle-bounded timeout.
module fpro_avalon_master_core #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RWAIT = 2'd2
    } state_t;

    localparam logic [9:0] TC_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [31:0] addr_reg_q, addr_reg_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        dir_q, dir_d;
    logic        done_q, done_d;
    logic        tout_q, tout_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] avm_address_q, avm_address_d;
    logic [31:0] avm_writedata_q, avm_writedata_d;
    logic [3:0]  avm_byteenable_q, avm_byteenable_d;
    logic        xfer_dir_q, xfer_dir_d;

    logic        busy;
    logic        wr_en;
    logic        go;
    logic        unused_inputs;

    assign busy  = (state_q != ST_IDLE);
    assign wr_en = cs && write;
    assign go    = wr_en && !busy && (addr == 5'd2) && wr_data[0];

    assign unused_inputs = ^{read, wr_data[3:2]};

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        addr_reg_d       = addr_reg_q;
        wdata_d          = wdata_q;
        be_d             = be_q;
        dir_d            = dir_q;
        done_d           = done_q;
        tout_d           = tout_q;
        rdata_d          = rdata_q;
        avm_address_d    = avm_address_q;
        avm_writedata_d  = avm_writedata_q;
        avm_byteenable_d = avm_byteenable_q;
        xfer_dir_d       = xfer_dir_q;

        if (wr_en && !busy) begin
            case (addr)
                5'd0: addr_reg_d = wr_data;
                5'd1: wdata_d    = wr_data;
                5'd2: begin
                    be_d  = wr_data[7:4];
                    dir_d = wr_data[1];
                end
                default: ;
            endcase
        end

        if (wr_en && (addr == 5'd3)) begin
            done_d = 1'b0;
            tout_d = 1'b0;
        end

        // FSM updates come after the STATUS clear so a coincident completion wins
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    avm_address_d    = {addr_reg_q[31:2], 2'b00};
                    avm_writedata_d  = wdata_q;
                    xfer_dir_d       = wr_data[1];
                    if (wr_data[1] && (wr_data[7:4] != 4'h0))
                        avm_byteenable_d = wr_data[7:4];
                    else
                        avm_byteenable_d = 4'hF;
                    done_d  = 1'b0;
                    tout_d  = 1'b0;
                    cnt_d   = 10'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!avm_waitrequest) begin
                    cnt_d = cnt_q + 10'd1;
                    if (xfer_dir_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RWAIT;
                    end
                end else if (cnt_q == TC_LAST) begin
                    tout_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_RWAIT: begin
                if (avm_readdatavalid) begin
                    rdata_d = avm_readdata;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == TC_LAST) begin
                    tout_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= 10'd0;
            addr_reg_q       <= 32'd0;
            wdata_q          <= 32'd0;
            be_q             <= 4'd0;
            dir_q            <= 1'b0;
            done_q           <= 1'b0;
            tout_q           <= 1'b0;
            rdata_q          <= 32'd0;
            avm_address_q    <= 32'd0;
            avm_writedata_q  <= 32'd0;
            avm_byteenable_q <= 4'd0;
            xfer_dir_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            addr_reg_q       <= addr_reg_d;
            wdata_q          <= wdata_d;
            be_q             <= be_d;
            dir_q            <= dir_d;
            done_q           <= done_d;
            tout_q           <= tout_d;
            rdata_q          <= rdata_d;
            avm_address_q    <= avm_address_d;
            avm_writedata_q  <= avm_writedata_d;
            avm_byteenable_q <= avm_byteenable_d;
            xfer_dir_q       <= xfer_dir_d;
        end
    end

    assign avm_address    = avm_address_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_byteenable = avm_byteenable_q;
    assign avm_read       = (state_q == ST_REQ) && !xfer_dir_q;
    assign avm_write      = (state_q == ST_REQ) && xfer_dir_q;

    always_comb begin
        rd_data = 32'd0;
        case (addr)
            5'd0: rd_data = addr_reg_q;
            5'd1: rd_data = wdata_q;
            5'd2: rd_data = {24'd0, be_q, 2'b00, dir_q, 1'b0};
            5'd3: rd_data = {29'd0, tout_q, done_q, busy};
            5'd4: rd_data = rdata_q;
            default: rd_data = 32'd0;
        endcase
    end

endmodule
